// File: rtl/jt49_pkg.sv
// Shared constants and types for the JT49 envelope generator: shape bit positions,
// default widths and the end-of-cycle action decode.
package jt49_pkg;

    localparam int SH_CONT = 3;
    localparam int SH_ATT  = 2;
    localparam int SH_ALT  = 1;
    localparam int SH_HOLD = 0;

    localparam int DEF_PW = 16;
    localparam int DEF_EW = 5;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } env_dir_e;

    typedef enum logic [1:0] {
        END_STOP,
        END_HOLD,
        END_ALT,
        END_SAW
    } end_action_e;

    // Action taken when the step counter wraps; earlier tests take priority.
    function automatic end_action_e end_action(input logic [3:0] shape);
        if (!shape[SH_CONT])
            return END_STOP;
        else if (shape[SH_HOLD])
            return END_HOLD;
        else if (shape[SH_ALT])
            return END_ALT;
        else
            return END_SAW;
    endfunction

endpackage

// File: rtl/jt49_env_prescaler.sv
// Envelope period counter: counts enabled cen256 pulses and emits a one-cycle step
// when the count reaches the programmed period (0 treated as 1).
module jt49_env_prescaler
    import jt49_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen256,
    input  logic [PW-1:0] period,
    input  logic          clr,
    input  logic          en,
    output logic          step
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW:0]   cnt_inc;
    logic [PW:0]   limit;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        cnt_d   = cnt_q;
        step    = 1'b0;
        cnt_inc = {1'b0, cnt_q} + (PW+1)'(1);
        limit   = (period == '0) ? (PW+1)'(1) : {1'b0, period};
        if (clr) begin
            cnt_d = '0;
        end else if (cen256 && en) begin
            // >= rather than == so lowering the period below the count steps immediately.
            if (cnt_inc >= limit) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_inc[PW-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jt49_env_gen.sv
// AY/YM envelope generator: steps an EW-bit level through the attack/alternate/hold/
// continue shapes, one step per programmed number of cen256 pulses.
module jt49_env_gen
    import jt49_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int EW = DEF_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen256,
    input  logic [PW-1:0] period,
    input  logic [3:0]    shape,
    input  logic          restart,
    output logic [EW-1:0] env,
    output logic          env_stb,
    output logic          stopped
);

    localparam logic [EW-1:0] STEP_MAX = '1;

    logic [EW-1:0] step_q, step_d;
    env_dir_e      dir_q, dir_d;
    logic          stopped_q, stopped_d;
    logic [3:0]    shape_q, shape_d;
    logic [EW-1:0] env_q, env_d;
    logic          env_stb_q, env_stb_d;
    logic          step_evt;

    jt49_env_prescaler #(.PW(PW)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .cen256 (cen256),
        .period (period),
        .clr    (restart),
        .en     (!stopped_q),
        .step   (step_evt)
    );

    always_comb begin
        step_d    = step_q;
        dir_d     = dir_q;
        stopped_d = stopped_q;
        shape_d   = shape_q;
        env_d     = env_q;
        env_stb_d = 1'b0;

        if (restart) begin
            shape_d   = shape;
            step_d    = '0;
            dir_d     = env_dir_e'(shape[SH_ATT]);
            stopped_d = 1'b0;
        end else if (step_evt) begin
            if (step_q != STEP_MAX) begin
                step_d = step_q + EW'(1);
            end else begin
                unique case (end_action(shape_q))
                    END_STOP: stopped_d = 1'b1;
                    END_HOLD: stopped_d = 1'b1;
                    END_ALT: begin
                        dir_d  = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        step_d = '0;
                    end
                    END_SAW:  step_d = '0;
                endcase
            end
        end

        // Frozen level: zero for one-shot shapes, otherwise the final level, flipped by ALT.
        if (stopped_d) begin
            if (!shape_d[SH_CONT])
                env_d = '0;
            else
                env_d = {EW{dir_d == DIR_UP}} ^ {EW{shape_d[SH_ALT]}};
        end else begin
            env_d = (dir_d == DIR_UP) ? step_d : ~step_d;
        end

        env_stb_d = step_evt && !restart && (env_d != env_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q    <= '0;
            dir_q     <= DIR_DOWN;
            stopped_q <= 1'b1;
            shape_q   <= '0;
            env_q     <= '0;
            env_stb_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            dir_q     <= dir_d;
            stopped_q <= stopped_d;
            shape_q   <= shape_d;
            env_q     <= env_d;
            env_stb_q <= env_stb_d;
        end
    end

    assign env     = env_q;
    assign env_stb = env_stb_q;
    assign stopped = stopped_q;

endmodule

// File: tb/tb_jt49_env_gen.sv
// Directed self-checking bench for jt49_env_gen: reset, each shape family, period
// boundaries, restart/step collision and mid-envelope reset.
`timescale 1ns/1ps
module tb_jt49_env_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen256 = 1'b0;
    logic [15:0] period = 16'd0;
    logic [3:0]  shape = 4'h0;
    logic        restart = 1'b0;
    logic [4:0]  env;
    logic        env_stb;
    logic        stopped;

    int checks   = 0;
    int failures = 0;

    jt49_env_gen dut (
        .clk     (clk),
        .rst     (rst),
        .cen256  (cen256),
        .period  (period),
        .shape   (shape),
        .restart (restart),
        .env     (env),
        .env_stb (env_stb),
        .stopped (stopped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart(input logic [3:0] sh);
        cen256  = 1'b0;
        shape   = sh;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        shape   = ~sh;
    endtask

    task automatic expect_out(input string name, input logic [4:0] e_env,
                              input logic e_stb, input logic e_stop);
        checks++;
        if (env !== e_env || env_stb !== e_stb || stopped !== e_stop) begin
            failures++;
            $display("FAIL %s env=%0d stb=%0b stopped=%0b expected env=%0d stb=%0b stopped=%0b",
                     name, env, env_stb, stopped, e_env, e_stb, e_stop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        expect_out("reset_state", 5'd0, 1'b0, 1'b1);
        rst    = 1'b0;
        cen256 = 1'b1;
        period = 16'd1;
        repeat (4) tick();
        expect_out("reset_cen_ignored", 5'd0, 1'b0, 1'b1);
        cen256 = 1'b0;
    endtask

    task automatic test_attack_hold();
        int stb_cnt = 0;
        period = 16'd1;
        do_restart(4'hD);
        expect_out("t1_restart", 5'd0, 1'b0, 1'b0);
        cen256 = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (env_stb) stb_cnt++;
            expect_out($sformatf("t1_ramp_%0d", i), 5'(i), 1'b1, 1'b0);
        end
        tick();
        if (env_stb) stb_cnt++;
        expect_out("t1_hold_enter", 5'd31, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (env_stb) stb_cnt++;
        end
        expect_out("t1_hold_stay", 5'd31, 1'b0, 1'b1);
        checks++;
        if (stb_cnt !== 31) begin
            failures++;
            $display("FAIL t1_stb_count got=%0d expected=31", stb_cnt);
        end
        cen256 = 1'b0;
    endtask

    task automatic test_sawtooth_down();
        period = 16'd3;
        do_restart(4'h8);
        expect_out("t2_restart", 5'd31, 1'b0, 1'b0);
        cen256 = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            tick();
            expect_out($sformatf("t2_wait_%0d", k), 5'(32 - k), 1'b0, 1'b0);
            tick();
            expect_out($sformatf("t2_step_%0d", k), 5'(31 - k), 1'b1, 1'b0);
        end
        repeat (3) tick();
        expect_out("t2_wrap", 5'd31, 1'b1, 1'b0);
        repeat (3) tick();
        expect_out("t2_after_wrap", 5'd30, 1'b1, 1'b0);
        cen256 = 1'b0;
    endtask

    task automatic test_triangle_period0();
        period = 16'd0;
        do_restart(4'hE);
        expect_out("t3_restart", 5'd0, 1'b0, 1'b0);
        cen256 = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            expect_out($sformatf("t3_up_%0d", i), 5'(i), 1'b1, 1'b0);
        end
        tick();
        expect_out("t3_top_repeat", 5'd31, 1'b0, 1'b0);
        for (int i = 30; i >= 0; i--) begin
            tick();
            expect_out($sformatf("t3_down_%0d", i), 5'(i), 1'b1, 1'b0);
        end
        tick();
        expect_out("t3_bottom_repeat", 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("t3_up_again", 5'd1, 1'b1, 1'b0);
        cen256 = 1'b0;
    endtask

    task automatic test_decay_oneshot();
        period = 16'd2;
        do_restart(4'h0);
        expect_out("t4_restart", 5'd31, 1'b0, 1'b0);
        cen256 = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            tick();
            expect_out($sformatf("t4_step_%0d", k), 5'(31 - k), 1'b1, 1'b0);
        end
        tick();
        tick();
        expect_out("t4_stop", 5'd0, 1'b0, 1'b1);
        repeat (4) tick();
        expect_out("t4_stay", 5'd0, 1'b0, 1'b1);
        cen256 = 1'b0;
    endtask

    task automatic test_attack_drop();
        period = 16'd1;
        do_restart(4'h4);
        cen256 = 1'b1;
        repeat (31) tick();
        expect_out("t4b_top", 5'd31, 1'b1, 1'b0);
        tick();
        expect_out("t4b_drop", 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("t4b_stay", 5'd0, 1'b0, 1'b1);
        cen256 = 1'b0;
    endtask

    task automatic test_restart_collision();
        period = 16'd4;
        do_restart(4'hB);
        cen256 = 1'b1;
        repeat (4) tick();
        expect_out("t5_first_step", 5'd30, 1'b1, 1'b0);
        repeat (3) tick();
        expect_out("t5_pre_collide", 5'd30, 1'b0, 1'b0);
        shape   = 4'hB;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        shape   = 4'h0;
        expect_out("t5_restart_wins", 5'd31, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_out($sformatf("t5_cnt_cleared_%0d", i), 5'd31, 1'b0, 1'b0);
        end
        tick();
        expect_out("t5_step_after_4", 5'd30, 1'b1, 1'b0);
        period = 16'd1;
        repeat (30) tick();
        expect_out("t5_bottom", 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("t5_hold_flip", 5'd31, 1'b1, 1'b1);
        repeat (2) tick();
        expect_out("t5_hold_stay", 5'd31, 1'b0, 1'b1);
        cen256 = 1'b0;
    endtask

    task automatic test_reset_and_period_drop();
        period = 16'd100;
        do_restart(4'h8);
        cen256 = 1'b1;
        repeat (50) tick();
        expect_out("t6_mid_count", 5'd31, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("t6_after_rst", 5'd0, 1'b0, 1'b1);
        repeat (5) tick();
        expect_out("t6_rst_stays", 5'd0, 1'b0, 1'b1);

        period = 16'd100;
        do_restart(4'hC);
        cen256 = 1'b1;
        repeat (50) tick();
        expect_out("t6b_mid_count", 5'd0, 1'b0, 1'b0);
        period = 16'd5;
        tick();
        expect_out("t6b_drop_step", 5'd1, 1'b1, 1'b0);
        repeat (4) tick();
        expect_out("t6b_wait", 5'd1, 1'b0, 1'b0);
        tick();
        expect_out("t6b_next_step", 5'd2, 1'b1, 1'b0);
        cen256 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack_hold();
        test_sawtooth_down();
        test_triangle_period0();
        test_decay_oneshot();
        test_attack_drop();
        test_restart_collision();
        test_reset_and_period_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
